mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single external memory port between the instruction-cache refill path and the data-memory path of the single-cycle core. One transaction is outstanding at a time. The block arbitrates round-robin on contention, holds the winning request on the bus until acknowledge, and returns read data plus a one-cycle ready pulse to the winner. A watchdog terminates hung transactions with an error pulse, which the datapath routes to the CSR access-fault inputs.

## Interface
- `XLEN`, 32, data/address width
- `TIMEOUT`, 64, max cycles a bus request waits for `i_mem_ack`; 0 disables the watchdog
- `i_clk`  in  1  clock; all logic on rising edge
- `i_rst`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- `i_ic_req`  in  1  instruction refill request; held until `o_ic_ready`
- `i_ic_addr`  in  XLEN  refill word address
- `o_ic_data`  out  XLEN  refill data, valid with `o_ic_ready`
- `o_ic_ready`  out  1  one-cycle completion pulse for instruction side
- `o_ic_err`  out  1  one-cycle timeout pulse, coincident with `o_ic_ready`
- `i_dm_req`  in  1  data request; held until `o_dm_ready`
- `i_dm_wen`  in  1  1 = write, 0 = read
- `i_dm_addr`  in  XLEN  data address
- `i_dm_wdata`  in  XLEN  write data
- `i_dm_be`  in  4  byte enables; ignored on reads
- `o_dm_rdata`  out  XLEN  read data, valid with `o_dm_ready`
- `o_dm_ready`  out  1  one-cycle completion pulse for data side
- `o_dm_err`  out  1  one-cycle timeout pulse, coincident with `o_dm_ready`
- `o_mem_req`  out  1  bus request, held until ack or timeout
- `o_mem_we`, `o_mem_addr` (XLEN), `o_mem_wdata` (XLEN), `o_mem_be` (4)  out  bus command, stable while `o_mem_req`=1
- `i_mem_rdata`  in  XLEN  bus read data, valid with ack
- `i_mem_ack`  in  1  bus completion, single cycle

## Operation
- FSM states: IDLE, BUS_I, BUS_D, RESP.
- IDLE transitions:
  - Only `i_ic_req` → BUS_I.
  - Only `i_dm_req` → BUS_D.
  - Both requests → the side not granted last time (`last_gnt`). `last_gnt` resets to I, so the first contention grants D.
  - On the transition, the command is registered into the `o_mem_*` outputs and `last_gnt` is updated.
- BUS_I/BUS_D:
  - `o_mem_req`=1 with the registered command.
  - Instruction transactions drive `o_mem_we`=0 and `o_mem_be`=4'hF.
  - The watchdog counter increments every cycle.
  - On `i_mem_ack`: latch `i_mem_rdata` into the winner's data output, go to RESP.
  - On counter == TIMEOUT-1 without ack: set the winner's err flag, drive its data output to 0, go to RESP.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP:
  - `o_mem_req`=0.
  - The winner's ready pulses (plus err if flagged).
  - Return to IDLE, which re-samples requests in the next cycle.
- A requester dropping its req mid-transaction does not abort the transaction. The ready pulse is still issued.
- Write data is never returned. `o_dm_rdata`=0 after a write.
- Data outputs hold their value until the next completion for the same side.

## Timing
- Reset:
  - FSM=IDLE, `last_gnt`=I, counter=0.
  - All outputs 0: `o_mem_req`, `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_mem_be`, both readies, both errs, `o_ic_data`, `o_dm_rdata`.
- Reset mid-transaction: FSM returns to IDLE at the next edge and `o_mem_req` drops. No ready is issued. A late `i_mem_ack` arriving in IDLE is ignored.
- Latency:
  - Request seen at edge 0 → `o_mem_req` high from cycle 1.
  - Ack in cycle k → ready/data in cycle k+1.
  - Minimum 3 cycles from req to ready (ack in cycle 1).
- Timeout: with TIMEOUT=N, `o_mem_req` is high for exactly N cycles, then ready+err follows in the next cycle.
- Back-to-back: at least one IDLE cycle separates transactions. The bus is never requested in RESP or IDLE.

## Test plan
- Read path: IC req, addr 0x100, ack in the 3rd bus cycle with 0xDEADBEEF → `o_ic_ready`=1 for one cycle with `o_ic_data`=0xDEADBEEF and `o_ic_err`=0. `o_mem_we`=0 and `o_mem_be`=F throughout.
- Write path: DM write, addr 0x2004, wdata 0x11223344, be=4'b0011 → bus carries exactly these values with we=1 until ack, then `o_dm_ready` pulses.
- Contention: both reqs held continuously, ack always in bus cycle 1 → grants D, I, D, I. Each ready occurs on its own side only, and an IDLE cycle appears between grants.
- Timeout: TIMEOUT=4, DM read, no ack → `o_mem_req` high for exactly 4 cycles, then `o_dm_ready`=`o_dm_err`=1 with `o_dm_rdata`=0. The next request then proceeds normally.
- Ack/timeout race: TIMEOUT=4, ack in bus cycle 4 with 0xCAFE → `o_*_err`=0 and data=0xCAFE.
- Reset mid-transaction: assert `i_rst` in bus cycle 2 of an IC read → all outputs 0 at the next edge and no ready pulse. An ack one cycle later is ignored. A fresh IC request after reset completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between icache refill and data paths
// Ports: i_clk/i_rst (sync, active-high); i_ic_* / o_ic_* instruction side;
//        i_dm_* / o_dm_* data side; o_mem_* / i_mem_* external bus.
//        Each side gets a one-cycle ready pulse, plus err on watchdog timeout.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ic_req,
  input  logic [XLEN-1:0] i_ic_addr,
  output logic [XLEN-1:0] o_ic_data,
  output logic            o_ic_ready,
  output logic            o_ic_err,
  input  logic            i_dm_req,
  input  logic            i_dm_wen,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wdata,
  input  logic [3:0]      i_dm_be,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_dm_ready,
  output logic            o_dm_err,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_mem_ack
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUS_I = 2'd1;
  localparam logic [1:0] BUS_D = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [1:0]      state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] ic_data_q, ic_data_d;
  logic [XLEN-1:0] dm_data_q, dm_data_d;
  logic            gnt_d_side;
  logic            tmo;
  // last_gnt: 0 = instruction side, 1 = data side; it also names the current winner
  assign gnt_d_side = i_dm_req && (!i_ic_req || !last_gnt_q);
  assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    ic_data_d  = ic_data_q;
    dm_data_d  = dm_data_q;
    case (state_q)
      IDLE: begin
        if (i_ic_req || i_dm_req) begin
          state_d    = gnt_d_side ? BUS_D : BUS_I;
          last_gnt_d = gnt_d_side;
          cnt_d      = '0;
          err_d      = 1'b0;
          we_d       = gnt_d_side && i_dm_wen;
          addr_d     = gnt_d_side ? i_dm_addr : i_ic_addr;
          wdata_d    = gnt_d_side ? i_dm_wdata : '0;
          be_d       = gnt_d_side ? i_dm_be : 4'hF;
        end
      end
      BUS_I, BUS_D: begin
        cnt_d = cnt_q + CW'(1);
        // ack takes priority over a coincident timeout
        if (i_mem_ack || tmo) begin
          state_d = RESP;
          err_d   = !i_mem_ack;
          if (last_gnt_q)
            dm_data_d = (i_mem_ack && !we_q) ? i_mem_rdata : '0;
          else
            ic_data_d = i_mem_ack ? i_mem_rdata : '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ic_data_q  <= '0;
      dm_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ic_data_q  <= ic_data_d;
      dm_data_q  <= dm_data_d;
    end
  end
  assign o_mem_req   = (state_q == BUS_I) || (state_q == BUS_D);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;
  assign o_ic_ready  = (state_q == RESP) && !last_gnt_q;
  assign o_dm_ready  = (state_q == RESP) && last_gnt_q;
  assign o_ic_err    = o_ic_ready && err_q;
  assign o_dm_err    = o_dm_ready && err_q;
  assign o_ic_data   = ic_data_q;
  assign o_dm_rdata  = dm_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with TIMEOUT=4
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic [31:0] ic_data;
  logic        ic_ready, ic_err;
  logic        dm_req = 1'b0;
  logic        dm_wen = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready, dm_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  int          errs = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ic_req(ic_req), .i_ic_addr(ic_addr), .o_ic_data(ic_data),
    .o_ic_ready(ic_ready), .o_ic_err(ic_err),
    .i_dm_req(dm_req), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_be(dm_be), .o_dm_rdata(dm_rdata),
    .o_dm_ready(dm_ready), .o_dm_err(dm_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_rdy", {30'd0, ic_ready, dm_ready}, 0);
    chk("rst_err", {30'd0, ic_err, dm_err}, 0);
    chk("rst_icd", ic_data, 0);
    chk("rst_dmd", dm_rdata, 0);
    rst = 1'b0;
    // read path: ack in third bus cycle
    ic_req = 1'b1;
    ic_addr = 32'h100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("rd_req%0d", c), 32'(mem_req), 1);
      chk($sformatf("rd_we%0d", c), 32'(mem_we), 0);
      chk($sformatf("rd_be%0d", c), 32'(mem_be), 32'hF);
      chk($sformatf("rd_addr%0d", c), mem_addr, 32'h100);
      chk($sformatf("rd_rdy%0d", c), 32'(ic_ready), 0);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    ic_req = 1'b0;
    chk("rd_ready", 32'(ic_ready), 1);
    chk("rd_data", ic_data, 32'hDEADBEEF);
    chk("rd_err", 32'(ic_err), 0);
    chk("rd_dmrdy", 32'(dm_ready), 0);
    chk("rd_resp_req", 32'(mem_req), 0);
    tick();
    chk("rd_pulse", 32'(ic_ready), 0);
    chk("rd_hold", ic_data, 32'hDEADBEEF);
    // contention: first contention after reset-era I grant goes to D
    ic_req = 1'b1;
    ic_addr = 32'h400;
    dm_req = 1'b1;
    dm_wen = 1'b0;
    dm_addr = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 0);
      tick();
      chk($sformatf("ct_req%0d", i), 32'(mem_req), 1);
      chk($sformatf("ct_addr%0d", i), mem_addr, g ? 32'h3000 : 32'h400);
      mem_ack = 1'b1;
      mem_rdata = 32'hA0 + 32'(i);
      tick();
      mem_ack = 1'b0;
      chk($sformatf("ct_icrdy%0d", i), 32'(ic_ready), g ? 0 : 1);
      chk($sformatf("ct_dmrdy%0d", i), 32'(dm_ready), g ? 1 : 0);
      chk($sformatf("ct_data%0d", i), g ? dm_rdata : ic_data, 32'hA0 + 32'(i));
      chk($sformatf("ct_respreq%0d", i), 32'(mem_req), 0);
      tick();
      chk($sformatf("ct_idlereq%0d", i), 32'(mem_req), 0);
      chk($sformatf("ct_idlerdy%0d", i), {30'd0, ic_ready, dm_ready}, 0);
      if (i == 3) begin
        ic_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    // write path
    dm_req = 1'b1;
    dm_wen = 1'b1;
    dm_addr = 32'h2004;
    dm_wdata = 32'h11223344;
    dm_be = 4'b0011;
    for (int c = 1; c <= 2; c++) begin
      tick();
      chk($sformatf("wr_req%0d", c), 32'(mem_req), 1);
      chk($sformatf("wr_we%0d", c), 32'(mem_we), 1);
      chk($sformatf("wr_addr%0d", c), mem_addr, 32'h2004);
      chk($sformatf("wr_wdata%0d", c), mem_wdata, 32'h11223344);
      chk($sformatf("wr_be%0d", c), 32'(mem_be), 32'h3);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    tick();
    mem_ack = 1'b0;
    dm_req = 1'b0;
    dm_wen = 1'b0;
    chk("wr_ready", 32'(dm_ready), 1);
    chk("wr_rdata", dm_rdata, 0);
    chk("wr_icrdy", 32'(ic_ready), 0);
    tick();
    // timeout: no ack, request held exactly 4 cycles
    dm_req = 1'b1;
    dm_addr = 32'h5000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("to_req%0d", c), 32'(mem_req), 1);
      chk($sformatf("to_rdy%0d", c), 32'(dm_ready), 0);
    end
    tick();
    dm_req = 1'b0;
    chk("to_req_drop", 32'(mem_req), 0);
    chk("to_ready", 32'(dm_ready), 1);
    chk("to_err", 32'(dm_err), 1);
    chk("to_rdata", dm_rdata, 0);
    chk("to_icerr", 32'(ic_err), 0);
    tick();
    chk("to_errpulse", 32'(dm_err), 0);
    // ack/timeout race in bus cycle 4: ack wins
    dm_req = 1'b1;
    dm_addr = 32'h6000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("rc_req%0d", c), 32'(mem_req), 1);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE;
    tick();
    mem_ack = 1'b0;
    dm_req = 1'b0;
    chk("rc_ready", 32'(dm_ready), 1);
    chk("rc_err", 32'(dm_err), 0);
    chk("rc_data", dm_rdata, 32'hCAFE);
    tick();
    // reset in bus cycle 2 of an IC read
    ic_req = 1'b1;
    ic_addr = 32'h600;
    tick();
    chk("mr_req1", 32'(mem_req), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ic_req = 1'b0;
    chk("mr_req", 32'(mem_req), 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_rdy", {30'd0, ic_ready, dm_ready}, 0);
    chk("mr_icd", ic_data, 0);
    chk("mr_dmd", dm_rdata, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'h99;
    tick();
    mem_ack = 1'b0;
    chk("late_rdy", 32'(ic_ready), 0);
    chk("late_req", 32'(mem_req), 0);
    tick();
    chk("late_rdy2", 32'(ic_ready), 0);
    chk("late_icd", ic_data, 0);
    ic_req = 1'b1;
    ic_addr = 32'h700;
    tick();
    chk("fr_req", 32'(mem_req), 1);
    chk("fr_addr", mem_addr, 32'h700);
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    ic_req = 1'b0;
    chk("fr_ready", 32'(ic_ready), 1);
    chk("fr_data", ic_data, 32'h12345678);
    chk("fr_err", 32'(ic_err), 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
